// File: rtl/fetch_sequencer.sv
// Instruction fetch and program-counter sequencer.
// Fetches 32-bit words over a req/valid handshake, holds the current word in
// an instruction register while it executes, and resolves the next PC from the
// control unit's pcControl code and the ALU compare flags.
module fetch_sequencer #(
   parameter int                ADDR_W        = 16,
   parameter logic [ADDR_W-1:0] RESET_PC      = '0,
   parameter int                FETCH_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_data,
   output logic [31:0]       instruction,
   output logic              instr_valid,
   input  logic [3:0]        pcControl,
   input  logic [20:0]       target,
   input  logic              flag_eq,
   input  logic              flag_below,
   input  logic              flag_above,
   input  logic              flag_zero,
   input  logic              stall,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              fault
);

   // Counter only needs to reach FETCH_TIMEOUT; a zero timeout keeps a 1-bit stub.
   localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(FETCH_TIMEOUT);

   localparam logic [3:0] PC_HLT = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [31:0]       instr_reg, instr_next;
   logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic              fault_reg, fault_next;

   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jump_tgt;
   logic              taken;
   logic              unused_target_bits;

   // Sequential address wraps naturally at 2^ADDR_W; jump target is truncated
   // or zero-extended to the address width.
   assign pc_inc   = pc_reg + ADDR_W'(1);
   assign jump_tgt = ADDR_W'(target);
   // Target bits above the address space are intentionally dropped.
   assign unused_target_bits = ^target;

   // Branch condition decode for the current pcControl code.
   always_comb begin
      taken = 1'b0;
      case (pcControl)
         4'd1:    taken = flag_eq;
         4'd2:    taken = flag_below;
         4'd3:    taken = flag_above;
         4'd4:    taken = !flag_eq;
         4'd5:    taken = flag_below | flag_eq;
         4'd6:    taken = flag_above | flag_eq;
         4'd7:    taken = !flag_zero;
         4'd8:    taken = flag_zero;
         4'd9:    taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Next-state logic: fetch handshake, timeout, PC selection, halt/resume.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      wait_cnt_next = wait_cnt_reg;
      fault_next    = fault_reg;
      case (state_reg)
         S_IDLE: begin
            wait_cnt_next = '0;
            state_next    = S_FETCH;
         end
         S_FETCH: begin
            if (imem_valid) begin
               instr_next    = imem_data;
               wait_cnt_next = '0;
               state_next    = S_EXEC;
            end else if (FETCH_TIMEOUT != 0) begin
               if (wait_cnt_reg + CNT_W'(1) == TIMEOUT_C) begin
                  fault_next = 1'b1;
                  state_next = S_FAULT;
               end else begin
                  wait_cnt_next = wait_cnt_reg + CNT_W'(1);
               end
            end
         end
         S_EXEC: begin
            // A stalled EXEC samples nothing, so a pending HLT waits for stall to drop.
            if (!stall) begin
               if (pcControl == PC_HLT) begin
                  state_next = S_HALT;
               end else begin
                  pc_next       = taken ? jump_tgt : pc_inc;
                  wait_cnt_next = '0;
                  state_next    = S_FETCH;
               end
            end
         end
         S_HALT: begin
            if (resume) begin
               pc_next       = pc_inc;
               wait_cnt_next = '0;
               state_next    = S_FETCH;
            end
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State register; synchronous active-low reset aborts any fetch in flight.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg    <= S_IDLE;
         pc_reg       <= RESET_PC;
         instr_reg    <= 32'h0;
         wait_cnt_reg <= '0;
         fault_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         instr_reg    <= instr_next;
         wait_cnt_reg <= wait_cnt_next;
         fault_reg    <= fault_next;
      end
   end

   assign imem_req    = (state_reg == S_FETCH);
   assign imem_addr   = pc_reg;
   assign instruction = instr_reg;
   assign instr_valid = (state_reg == S_EXEC);
   assign pc          = pc_reg;
   assign halted      = (state_reg == S_HALT);
   assign fault       = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of branch vectors plus
// hand-written sequences for reset, stall/halt/resume, timeout and mid-fetch reset.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [3:0]  pcControl;
   logic [20:0] target;
   logic        flag_eq, flag_below, flag_above, flag_zero;
   logic        stall, resume;
   logic [15:0] pc;
   logic        halted;
   logic        fault;

   logic        mem_en;
   int          total_cnt = 0;
   int          pass_cnt  = 0;
   logic [15:0] exp_pc;

   fetch_sequencer #(
      .ADDR_W        (16),
      .RESET_PC      (16'h0000),
      .FETCH_TIMEOUT (4)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_data   (imem_data),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .pcControl   (pcControl),
      .target      (target),
      .flag_eq     (flag_eq),
      .flag_below  (flag_below),
      .flag_above  (flag_above),
      .flag_zero   (flag_zero),
      .stall       (stall),
      .resume      (resume),
      .pc          (pc),
      .halted      (halted),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {~a, a};
   endfunction

   // Memory model: one-cycle latency, single-cycle valid strobe per request.
   always @(posedge clock) begin
      imem_valid <= mem_en && imem_req && !imem_valid;
      imem_data  <= mem_word(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic wait_exec();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL exec_wait: got no instr_valid expected instr_valid within 20 cycles");
   endtask

   task automatic clear_inputs();
      pcControl  = 4'd0;
      target     = 21'h0;
      flag_eq    = 1'b0;
      flag_below = 1'b0;
      flag_above = 1'b0;
      flag_zero  = 1'b0;
      stall      = 1'b0;
      resume     = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  code;
      logic [20:0] tgt;
      logic        eq;
      logic        below;
      logic        above;
      logic        zero;
      logic        taken;
   } vec_t;

   vec_t vecs [28];

   initial begin
      logic [15:0] nxt;

      //          code   target        eq    below above zero  taken
      vecs[0]  = '{4'd0,  21'h000040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'd1,  21'h000040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{4'd1,  21'h000080, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{4'd2,  21'h000090, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{4'd2,  21'h0000A0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'd3,  21'h0000B0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{4'd3,  21'h0000C0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{4'd4,  21'h0000D0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{4'd4,  21'h0000E0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{4'd5,  21'h000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{4'd5,  21'h000110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{4'd5,  21'h000120, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{4'd5,  21'h000130, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{4'd6,  21'h000140, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{4'd6,  21'h000150, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{4'd6,  21'h000160, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[16] = '{4'd6,  21'h000170, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[17] = '{4'd7,  21'h000180, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{4'd7,  21'h000190, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{4'd8,  21'h0001A0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[20] = '{4'd8,  21'h0001B0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{4'd9,  21'h0001C0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[22] = '{4'd12, 21'h0001D0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[23] = '{4'd15, 21'h0001E0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[24] = '{4'd11, 21'h0001F0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[25] = '{4'd9,  21'h1AFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[26] = '{4'd0,  21'h000077, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[27] = '{4'd9,  21'h1ABCDE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset values
      reset_n = 1'b0;
      mem_en  = 1'b1;
      clear_inputs();
      repeat (3) @(negedge clock);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_ivalid", 32'(instr_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_instr", instruction, 32'h0);
      reset_n = 1'b1;

      // Sequential fetch: addr 0,1,2,3 with instr_valid every third cycle
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (k % 3 == 0) begin
            chk("seq_ivalid", 32'(instr_valid), 32'h1);
            chk("seq_instr", instruction, mem_word(16'(k / 3 - 1)));
         end else begin
            chk("seq_ivalid", 32'(instr_valid), 32'h0);
         end
         if (k % 3 == 1) begin
            chk("seq_req", 32'(imem_req), 32'h1);
            chk("seq_addr", 32'(imem_addr), 32'(k / 3));
         end
         $display("seq cycle %0d req=%0b addr=%h ivalid=%0b", k, imem_req, imem_addr, instr_valid);
      end
      exp_pc = 16'h0003;

      // Branch table
      for (int v = 0; v < 28; v++) begin
         wait_exec();
         chk("vec_instr", instruction, mem_word(exp_pc));
         chk("vec_pc_exec", 32'(pc), 32'(exp_pc));
         pcControl  = vecs[v].code;
         target     = vecs[v].tgt;
         flag_eq    = vecs[v].eq;
         flag_below = vecs[v].below;
         flag_above = vecs[v].above;
         flag_zero  = vecs[v].zero;
         @(negedge clock);
         nxt = vecs[v].taken ? vecs[v].tgt[15:0] : exp_pc + 16'd1;
         chk("vec_next_pc", 32'(pc), 32'(nxt));
         chk("vec_req", 32'(imem_req), 32'h1);
         chk("vec_addr", 32'(imem_addr), 32'(nxt));
         $display("vec %0d code=%0d pc %h -> %h (expected %h)", v, vecs[v].code, exp_pc, pc, nxt);
         exp_pc = nxt;
         clear_inputs();
      end

      // HLT under stall: no halt while stalled, resume ignored outside HALT
      wait_exec();
      pcControl = 4'd10;
      stall     = 1'b1;
      resume    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("stall_halted", 32'(halted), 32'h0);
         chk("stall_ivalid", 32'(instr_valid), 32'h1);
         chk("stall_pc", 32'(pc), 32'(exp_pc));
         chk("stall_instr", instruction, mem_word(exp_pc));
         $display("stall cycle %0d halted=%0b pc=%h", i, halted, pc);
      end
      stall  = 1'b0;
      resume = 1'b0;
      @(negedge clock);
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_req", 32'(imem_req), 32'h0);
      chk("halt_pc", 32'(pc), 32'(exp_pc));
      pcControl = 4'd0;
      @(negedge clock);
      chk("halt_hold", 32'(halted), 32'h1);
      $display("halt pc=%h halted=%0b", pc, halted);

      // Resume into a fetch that never completes -> timeout after 4 FETCH cycles
      mem_en = 1'b0;
      resume = 1'b1;
      @(negedge clock);
      resume = 1'b0;
      exp_pc = exp_pc + 16'd1;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_req", 32'(imem_req), 32'h1);
      chk("resume_addr", 32'(imem_addr), 32'(exp_pc));
      $display("resume addr=%h", imem_addr);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clock);
         chk("tmo_fault_early", 32'(fault), 32'h0);
         chk("tmo_req_early", 32'(imem_req), 32'h1);
      end
      @(negedge clock);
      chk("tmo_fault", 32'(fault), 32'h1);
      chk("tmo_req", 32'(imem_req), 32'h0);
      chk("tmo_halted", 32'(halted), 32'h0);
      resume = 1'b1;
      @(negedge clock);
      resume = 1'b0;
      chk("fault_sticky", 32'(fault), 32'h1);
      chk("fault_req", 32'(imem_req), 32'h0);
      chk("fault_pc", 32'(pc), 32'(exp_pc));
      $display("fault=%0b req=%0b pc=%h", fault, imem_req, pc);

      // Reset out of FAULT
      reset_n = 1'b0;
      @(negedge clock);
      chk("frst_fault", 32'(fault), 32'h0);
      chk("frst_pc", 32'(pc), 32'h0);
      chk("frst_instr", instruction, 32'h0);
      chk("frst_req", 32'(imem_req), 32'h0);
      chk("frst_ivalid", 32'(instr_valid), 32'h0);
      chk("frst_halted", 32'(halted), 32'h0);
      mem_en  = 1'b1;
      reset_n = 1'b1;

      // Mid-fetch reset; the late memory strobe must be ignored
      @(negedge clock);
      chk("mid_req", 32'(imem_req), 32'h1);
      reset_n = 1'b0;
      @(negedge clock);
      chk("mid_rst_req", 32'(imem_req), 32'h0);
      chk("mid_rst_pc", 32'(pc), 32'h0);
      chk("mid_rst_instr", instruction, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("late_ivalid", 32'(instr_valid), 32'h0);
      chk("late_instr", instruction, 32'h0);
      chk("late_req", 32'(imem_req), 32'h1);
      $display("mid-fetch reset req=%0b instr=%h", imem_req, instruction);
      exp_pc = 16'h0000;
      wait_exec();
      chk("restart_instr", instruction, mem_word(exp_pc));
      chk("restart_pc", 32'(pc), 32'(exp_pc));
      $display("restart pc=%h instr=%h", pc, instruction);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
